// File: rtl/dp_ctrl_pkg.sv
// Shared types and constants for the ARM data-processing control sequencer:
// FSM states, ALU opcodes, condition codes and RSLCT field layout.
package dp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_PCINC
  } state_t;

  // ARM data-processing opcodes as presented on the 5-bit ALU OP bus
  localparam logic [4:0] OPC_AND    = 5'd0;
  localparam logic [4:0] OPC_EOR    = 5'd1;
  localparam logic [4:0] OPC_SUB    = 5'd2;
  localparam logic [4:0] OPC_RSB    = 5'd3;
  localparam logic [4:0] OPC_ADD    = 5'd4;
  localparam logic [4:0] OPC_ADC    = 5'd5;
  localparam logic [4:0] OPC_SBC    = 5'd6;
  localparam logic [4:0] OPC_RSC    = 5'd7;
  localparam logic [4:0] OPC_TST    = 5'd8;
  localparam logic [4:0] OPC_TEQ    = 5'd9;
  localparam logic [4:0] OPC_CMP    = 5'd10;
  localparam logic [4:0] OPC_CMN    = 5'd11;
  localparam logic [4:0] OPC_ORR    = 5'd12;
  localparam logic [4:0] OPC_MOV    = 5'd13;
  localparam logic [4:0] OPC_BIC    = 5'd14;
  localparam logic [4:0] OPC_MVN    = 5'd15;
  localparam logic [4:0] OPC_PASS_B = 5'd16;
  localparam logic [4:0] OPC_INC4   = 5'd17;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam int RS_RN_LSB = 16;
  localparam int RS_RD_LSB = 12;
  localparam int RS_RS_LSB = 8;
  localparam int RS_RM_LSB = 4;

  // TST/TEQ/CMP/CMN: flags-only, never written back
  function automatic logic is_cmp(input logic [3:0] opc);
    return opc[3:2] == 2'b10;
  endfunction

  function automatic logic [19:0] make_rslct(input logic [3:0] rn, input logic [3:0] rd,
                                             input logic [3:0] rs, input logic [3:0] rm);
    logic [19:0] r;
    r = '0;
    r[RS_RN_LSB +: 4] = rn;
    r[RS_RD_LSB +: 4] = rd;
    r[RS_RS_LSB +: 4] = rs;
    r[RS_RM_LSB +: 4] = rm;
    return r;
  endfunction

endpackage

// File: rtl/dp_ctrl_seq_cond_eval.sv
// ARM condition-field evaluator: pass=1 when cond holds for FLAGS {N,Z,C,V}.
// Code 0xF (NV) never passes.
module cond_eval
  import dp_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] FLAGS,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = FLAGS;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/dp_ctrl_seq.sv
// Multi-cycle control sequencer for ARM data-processing instructions.
// Macro COND_EXEC_EN enables condition-field evaluation; otherwise every word runs as AL.
module dp_ctrl_seq
  import dp_ctrl_pkg::*;
#(
  parameter logic [3:0] PC_REG    = 4'd15,
  parameter logic [4:0] OP_PASS_B = dp_ctrl_pkg::OPC_PASS_B,
  parameter logic [4:0] OP_INC4   = dp_ctrl_pkg::OPC_INC4
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        ir_valid,
  input  logic [31:0] ir_data,
  output logic        ir_ready,
  input  logic [3:0]  FLAGS,
  output logic [31:0] IR,
  output logic [19:0] RSLCT,
  output logic [4:0]  OP,
  output logic        S,
  output logic        ALU_OUT,
  output logic        LOAD,
  output logic        LOADPC,
  output logic        IR_CU,
  output logic        done,
  output logic        undef
);

  // Pass-through opcode belongs to the shifter-only path, which this sequencer never issues
  localparam logic [4:0] unused_op_pass_b = OP_PASS_B;

  state_t state;
  logic   cond_pass;
  logic   dp_word;
  logic   cmp_op;
  logic   rd_is_pc;

  assign dp_word  = (IR[27:26] == 2'b00);
  assign cmp_op   = is_cmp(IR[24:21]);
  assign rd_is_pc = (IR[15:12] == PC_REG);
  assign IR_CU    = 1'b1;

`ifdef COND_EXEC_EN
  cond_eval u_cond_eval (
    .cond  (IR[31:28]),
    .FLAGS (FLAGS),
    .pass  (cond_pass)
  );
`else
  logic unused_flags;
  assign unused_flags = ^FLAGS;
  assign cond_pass    = 1'b1;
`endif

  // Outputs are registered: each branch loads the values for the state being entered
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state    <= ST_IDLE;
      IR       <= '0;
      RSLCT    <= '0;
      OP       <= OP_INC4;
      S        <= 1'b0;
      ALU_OUT  <= 1'b0;
      LOAD     <= 1'b0;
      LOADPC   <= 1'b0;
      done     <= 1'b0;
      undef    <= 1'b0;
      ir_ready <= 1'b1;
    end else begin
      LOAD   <= 1'b0;
      LOADPC <= 1'b0;
      done   <= 1'b0;
      undef  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ir_valid) begin
            state    <= ST_DECODE;
            IR       <= ir_data;
            ir_ready <= 1'b0;
            RSLCT    <= make_rslct(ir_data[19:16], ir_data[15:12], ir_data[11:8], ir_data[3:0]);
            OP       <= {1'b0, ir_data[24:21]};
            S        <= 1'b0;
            ALU_OUT  <= 1'b0;
          end
        end
        ST_DECODE: begin
          if (!dp_word || !cond_pass) begin
            state   <= ST_PCINC;
            RSLCT   <= make_rslct(PC_REG, PC_REG, 4'h0, 4'h0);
            OP      <= OP_INC4;
            S       <= 1'b0;
            ALU_OUT <= 1'b1;
            LOADPC  <= 1'b1;
            done    <= 1'b1;
            undef   <= !dp_word;
          end else begin
            state   <= ST_EXEC;
            ALU_OUT <= 1'b1;
            S       <= IR[20] | cmp_op;
          end
        end
        ST_EXEC: begin
          state   <= ST_WB;
          S       <= 1'b0;
          ALU_OUT <= 1'b1;
          // A PC destination retires here: the write itself is the PC update
          if (!cmp_op) begin
            if (rd_is_pc) begin
              LOADPC <= 1'b1;
              done   <= 1'b1;
            end else begin
              LOAD <= 1'b1;
            end
          end
        end
        ST_WB: begin
          if (!cmp_op && rd_is_pc) begin
            state    <= ST_IDLE;
            ir_ready <= 1'b1;
            RSLCT    <= '0;
            OP       <= OP_INC4;
            S        <= 1'b0;
            ALU_OUT  <= 1'b0;
          end else begin
            state   <= ST_PCINC;
            RSLCT   <= make_rslct(PC_REG, PC_REG, 4'h0, 4'h0);
            OP      <= OP_INC4;
            S       <= 1'b0;
            ALU_OUT <= 1'b1;
            LOADPC  <= 1'b1;
            done    <= 1'b1;
          end
        end
        ST_PCINC: begin
          state    <= ST_IDLE;
          ir_ready <= 1'b1;
          RSLCT    <= '0;
          OP       <= OP_INC4;
          S        <= 1'b0;
          ALU_OUT  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          ir_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dp_ctrl_seq.sv
// Scoreboard bench for dp_ctrl_seq: stimulus pushes per-instruction expectations
// from a rule-level model; a negedge monitor collects the trace and checks on done.
module tb_dp_ctrl_seq;

  logic        Clk, RESET, ir_valid, ir_ready;
  logic [31:0] ir_data, IR;
  logic [3:0]  FLAGS;
  logic [19:0] RSLCT;
  logic [4:0]  OP;
  logic        S, ALU_OUT, LOAD, LOADPC, IR_CU, done, undef;

  dp_ctrl_seq dut (
    .Clk(Clk), .RESET(RESET), .ir_valid(ir_valid), .ir_data(ir_data), .ir_ready(ir_ready),
    .FLAGS(FLAGS), .IR(IR), .RSLCT(RSLCT), .OP(OP), .S(S), .ALU_OUT(ALU_OUT), .LOAD(LOAD),
    .LOADPC(LOADPC), .IR_CU(IR_CU), .done(done), .undef(undef)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int          lat;
    int          nundef;
    int          nload;
    int          nloadpc;
    bit          s_any;
    logic [4:0]  op1;
    logic [4:0]  done_op;
    logic [3:0]  rd;
    logic [31:0] ir;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] fl);
    bit n, z, cy, v;
    {n, z, cy, v} = fl;
    case (c)
      0: return z;             1: return !z;
      2: return cy;            3: return !cy;
      4: return n;             5: return !n;
      6: return v;             7: return !v;
      8: return cy && !z;      9: return !cy || z;
      10: return n == v;       11: return n != v;
      12: return !z && n == v; 13: return z || n != v;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // What the datapath should observe for one instruction word
  function automatic exp_t model(input logic [31:0] w, input logic [3:0] fl);
    exp_t e;
    bit is_undef, pass, flags_only;
    int opc;
    opc        = int'(w[24:21]);
    is_undef   = (w[27:26] != 2'b00);
    flags_only = (opc >= 8 && opc <= 11);
`ifdef COND_EXEC_EN
    pass = cond_holds(w[31:28], fl);
`else
    pass = 1'b1;
`endif
    e.ir = w; e.op1 = 5'(opc); e.rd = w[15:12]; e.nloadpc = 1;
    e.nundef = is_undef ? 1 : 0;
    if (is_undef || !pass) begin
      e.lat = 2; e.nload = 0; e.s_any = 0; e.done_op = 5'd17;
    end else if (!flags_only && w[15:12] == 4'd15) begin
      e.lat = 3; e.nload = 0; e.s_any = w[20]; e.done_op = 5'(opc);
    end else begin
      e.lat = 4; e.nload = flags_only ? 0 : 1; e.s_any = w[20] || flags_only; e.done_op = 5'd17;
    end
    return e;
  endfunction

  // Monitor state
  bit          acc_pend = 0, busy = 0, chk_ready = 0, both = 0, s_any = 0;
  int          cyc, nload, nloadpc, nundef;
  logic [4:0]  op1;
  logic [3:0]  load_rd;
  logic [31:0] ir_seen;

  always @(posedge Clk) begin
    if (RESET && ir_valid && ir_ready) begin
      acc_pend = 1;
      ir_seen  = ir_data;
    end
  end

  always @(negedge Clk) begin
    if (!RESET) begin
      acc_pend = 0; busy = 0; chk_ready = 0;
    end else begin
      if (chk_ready) begin
        chk("ir_ready_after_done", 32'(ir_ready), 1);
        chk_ready = 0;
      end
      if (acc_pend) begin
        acc_pend = 0; busy = 1; cyc = 0;
        nload = 0; nloadpc = 0; nundef = 0; both = 0; s_any = 0;
      end
      if (busy) begin
        cyc++;
        if (cyc == 1) begin
          op1 = OP;
          chk($sformatf("IR_latched ir=%h", ir_seen), IR, ir_seen);
        end
        if (S) s_any = 1;
        if (LOAD) begin nload++; load_rd = RSLCT[15:12]; end
        if (LOADPC) nloadpc++;
        if (LOAD && LOADPC) both = 1;
        if (undef) nundef++;
        if (done) begin
          busy = 0;
          chk_ready = 1;
          if (q.size() == 0) begin
            chk("unexpected_done", 32'(done), 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("latency ir=%h", e.ir), cyc, e.lat);
            chk($sformatf("undef ir=%h", e.ir), nundef, e.nundef);
            chk($sformatf("undef_with_done ir=%h", e.ir), 32'(undef), 32'(e.nundef));
            chk($sformatf("load_count ir=%h", e.ir), nload, e.nload);
            chk($sformatf("loadpc_count ir=%h", e.ir), nloadpc, e.nloadpc);
            chk($sformatf("load_and_loadpc ir=%h", e.ir), 32'(both), 0);
            chk($sformatf("s_seen ir=%h", e.ir), 32'(s_any), 32'(e.s_any));
            chk($sformatf("op_decode ir=%h", e.ir), op1, e.op1);
            chk($sformatf("op_at_done ir=%h", e.ir), OP, e.done_op);
            if (e.nload != 0) chk($sformatf("load_rd ir=%h", e.ir), load_rd, e.rd);
          end
        end else if (cyc > 8) begin
          busy = 0;
          chk("done_timeout", 32'(cyc), 32'(4));
        end
      end
    end
  end

  task automatic issue(input logic [31:0] w, input logic [3:0] fl, input bit push);
    int n = 0;
    @(negedge Clk);
    while (!ir_ready && n < 20) begin @(negedge Clk); n++; end
    if (!ir_ready) chk("ir_ready_timeout", 32'(ir_ready), 1);
    ir_data = w; FLAGS = fl; ir_valid = 1'b1;
    if (push) q.push_back(model(w, fl));
    @(posedge Clk);
    #1 ir_valid = 1'b0;
    ir_data = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || acc_pend || q.size() != 0) && n < 40) begin @(negedge Clk); n++; end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(negedge Clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_IR"}, IR, 0);
    chk({tag, "_RSLCT"}, 32'(RSLCT), 0);
    chk({tag, "_OP"}, 32'(OP), 17);
    chk({tag, "_strobes"}, 32'({S, ALU_OUT, LOAD, LOADPC, done, undef}), 0);
    chk({tag, "_ir_ready"}, 32'(ir_ready), 1);
    chk({tag, "_IR_CU"}, 32'(IR_CU), 1);
  endtask

  initial begin
    logic [31:0] w;
    RESET = 1'b1; ir_valid = 1'b0; ir_data = '0; FLAGS = '0;
    #3 RESET = 1'b0;
    #1 chk_reset_vals("rst");
    repeat (2) @(negedge Clk);
    #1 RESET = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      chk("idle_quiet", 32'({ALU_OUT, LOAD, LOADPC, done, undef}), 0);
    end

    issue(32'hE0812003, 4'b0000, 1); drain();  // ADD r2,r1,r3
    issue(32'hE1510003, 4'b0000, 1); drain();  // CMP r1,r3
    issue(32'h01A00001, 4'b0000, 1); drain();  // MOVEQ, Z clear
    issue(32'h01A00001, 4'b0100, 1); drain();  // MOVEQ, Z set
    issue(32'hEA000000, 4'b0000, 1); drain();  // branch: undefined here
    issue(32'hE1A0F001, 4'b0000, 1); drain();  // MOV pc,r1
    issue(32'hF0812003, 4'b1111, 1); drain();  // NV condition

    // Reset while the ADD sits in EXEC
    issue(32'hE0812003, 4'b0000, 0);
    @(negedge Clk);
    @(posedge Clk);
    #2 RESET = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge Clk);
    #1 RESET = 1'b1;
    issue(32'hE0812003, 4'b0000, 1); drain();

    // Randomised words, mostly data-processing, issued back-to-back
    for (int i = 0; i < 60; i++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[27:26] = 2'b00;
      if ($urandom_range(0, 5) == 0) w[15:12] = 4'hF;
      issue(w, 4'($urandom_range(0, 15)), 1);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge Clk);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dp_ctrl_seq.md
# dp_ctrl_seq

Control sequencer for ARM data-processing instructions, the driving end of the datapath built from RegisterFile, BarrelShifter and ARM_ALU. It accepts one 32-bit instruction word over a valid/ready handshake. It then steps a fixed multi-cycle sequence that emits the datapath controls: OP, S, ALU_OUT, LOAD, LOADPC, IR_CU and RSLCT. It also evaluates the ARM condition field against the ALU flags and finishes every instruction with a PC+4 update.

## Interface
Parameters:
- PC_REG, 15, register index used as PC for the increment step.
- OP_PASS_B, 16, ALU opcode: pass shifter output.
- OP_INC4, 17, ALU opcode: A+4, used for the PC update.

Ports:
- Clk  in  1  single clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- ir_valid  in  1  instruction word on ir_data is valid.
- ir_data  in  32  instruction word.
- ir_ready  out  1  sequencer can accept an instruction.
- FLAGS  in  4  ALU flags {N,Z,C,V}, registered in the ALU.
- IR  out  32  latched instruction, fed to BarrelShifter.
- RSLCT  out  20  register select: [19:16] Rn, [15:12] Rd, [11:8] Rs, [7:4] Rm, [3:0] 0.
- OP  out  5  ALU opcode.
- S  out  1  flag-update enable.
- ALU_OUT  out  1  ALU output enable.
- LOAD  out  1  register-file write strobe.
- LOADPC  out  1  PC write strobe.
- IR_CU  out  1  constant 1 (the RegisterFile operand path is always selected from IR).
- done  out  1  one-cycle pulse when an instruction retires.
- undef  out  1  one-cycle pulse, concurrent with done, for a non-data-processing word.

## Operation
States: IDLE, DECODE, EXEC, WB, PCINC.
- IDLE:
  - ir_ready=1; all strobes 0.
  - On ir_valid, latch ir_data into IR and go to DECODE.
- DECODE:
  - RSLCT is driven from IR fields; OP={1'b0,IR[24:21]}; S=0, ALU_OUT=0.
  - If IR[27:26]!=2'b00, set the undef flag and go to PCINC.
  - Else if the condition fails, go to PCINC.
  - Else go to EXEC.
- EXEC:
  - OP held; ALU_OUT=1.
  - S=IR[20], forced to 1 for opcodes 8..11 (TST/TEQ/CMP/CMN).
- WB:
  - ALU_OUT=1.
  - LOAD=1 unless the opcode is 8..11.
  - If Rd==PC_REG and LOAD, LOADPC=1 instead of LOAD and go to IDLE (no PCINC).
  - Otherwise go to PCINC.
- PCINC:
  - RSLCT Rn=Rd=PC_REG; OP=OP_INC4; ALU_OUT=1; S=0; LOADPC=1.
  - done=1; undef=1 if the flag is set; go to IDLE.
- The condition evaluator covers all 15 ARM codes (0x0..0xE) using FLAGS as sampled in DECODE. Code 0xF is treated as never.
- IR is held stable from latch until return to IDLE.
- ir_valid is ignored outside IDLE.

## Timing
- Reset (RESET=0, asynchronous):
  - state=IDLE, IR=0, RSLCT=0, OP=OP_INC4 (17), S=0, ALU_OUT=0, LOAD=0, LOADPC=0, done=0, undef=0, ir_ready=1.
- Reset mid-sequence aborts immediately; no partial strobe survives.
- Handshake: transfer occurs on a rising edge with ir_valid && ir_ready. ir_ready drops the cycle after acceptance.
- Latency from the accept edge:
  - Executed instruction: 4 cycles to done (DECODE, EXEC, WB, PCINC).
  - Condition-failed or undefined word: 2 cycles (DECODE, PCINC).
  - Rd==PC write: 3 cycles, with done asserted in WB.
- Back-to-back: a new instruction can be accepted on the edge after done. Throughput is 1 instruction per 5 cycles (executed) or 3 (skipped).
- LOAD and LOADPC are never both 1 in the same cycle.

## Configuration
- COND_EXEC_EN defined: condition evaluation is active as described above.
- COND_EXEC_EN undefined:
  - Every data-processing word is treated as AL.
  - FLAGS is unused; the skip path exists only for undef.

## Structure
- Package dp_ctrl_pkg holds:
  - the state enum;
  - OP constants (ARM opcodes 0..15, OP_PASS_B, OP_INC4);
  - cond-code constants;
  - RSLCT field offsets.
- Sub-module cond_eval: combinational, inputs cond[3:0] and FLAGS[3:0], output pass. It is instantiated only under COND_EXEC_EN.

## Test plan
- Reset then idle: RESET low at t=3 -> all outputs at reset values, ir_ready=1. Release -> no strobes while ir_valid=0.
- ADD r2,r1,r3 (ir_data=0xE0812003) -> OP=4 in DECODE/EXEC, LOAD=1 with RSLCT[15:12]=2 in WB, LOADPC=1 with OP=17 in PCINC, done 4 cycles after accept.
- CMP r1,r3 (0xE1510003) -> S=1 in EXEC, LOAD never asserted, done after 4 cycles.
- MOVEQ r0,r1 (0x01A00001):
  - with FLAGS=4'b0000 -> skip, no LOAD, done after 2 cycles;
  - with FLAGS=4'b0100 -> full 4-cycle execution.
- Undefined/branch word 0xEA000000 -> undef and done pulse together 2 cycles after accept, LOAD=0 throughout.
- RESET asserted in EXEC of an ADD -> outputs return to reset values asynchronously; the next accepted instruction runs the normal 4-cycle sequence.
